// File: rtl/mix_columns_seq_if.sv
// Handshake and data bus between ShiftRows, the MixColumns stage and AddRoundKey.
interface mix_columns_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         in_bypass;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, in_inv, in_bypass, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, in_inv, in_bypass, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns / InvMixColumns with final-round bypass.
// One 32-bit column per clock through a shared GF(2^8) column datapath.
module mix_columns_seq #(
  parameter int unsigned NCOL = 4
) (
  input logic               clk,
  input logic               rst_n,
  mix_columns_seq_if.slave  bus
);

  localparam int unsigned CW = $clog2(NCOL);
  localparam logic [CW-1:0] LAST_COL = CW'(NCOL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [127:0]   data_q, data_d;
  logic           inv_q, inv_d;
  logic           byp_q, byp_d;
  logic [127:0]   res_q, res_d;

  logic [31:0]    col_in;
  logic [31:0]    col_out;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant: shift-and-add over the constant's bits.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int unsigned i = 0; i < 4; i++) begin
      if (k[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_state = res_q;

  // Select the column addressed by the counter from the latched state.
  always_comb begin
    col_in = '0;
    for (int unsigned c = 0; c < NCOL; c++) begin
      if (col_q == CW'(c)) col_in = data_q[(NCOL-1-c)*32 +: 32];
    end
  end

  // Shared column datapath; row r uses the row-0 coefficients rotated right by r.
  always_comb begin
    logic [3:0] coef [4];
    logic [7:0] a    [4];
    logic [7:0] acc;
    col_out = '0;
    acc     = '0;
    if (inv_q) begin
      coef[0] = 4'he; coef[1] = 4'hb; coef[2] = 4'hd; coef[3] = 4'h9;
    end else begin
      coef[0] = 4'h2; coef[1] = 4'h3; coef[2] = 4'h1; coef[3] = 4'h1;
    end
    for (int unsigned j = 0; j < 4; j++) a[j] = col_in[31-8*j -: 8];
    for (int unsigned r = 0; r < 4; r++) begin
      acc = '0;
      for (int unsigned j = 0; j < 4; j++) acc = acc ^ gmul(a[j], coef[(j + 4 - r) % 4]);
      col_out[31-8*r -: 8] = byp_q ? a[r] : acc;
    end
  end

  // Next-state logic: FSM, column counter, input latch and result slot write.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    data_d  = data_q;
    inv_d   = inv_q;
    byp_d   = byp_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = BUSY;
          col_d   = '0;
          data_d  = bus.in_state;
          inv_d   = bus.in_inv;
          byp_d   = bus.in_bypass;
        end
      end
      BUSY: begin
        for (int unsigned c = 0; c < NCOL; c++) begin
          if (col_q == CW'(c)) res_d[(NCOL-1-c)*32 +: 32] = col_out;
        end
        col_d = col_q + CW'(1);
        if (col_q == LAST_COL) begin
          col_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      data_q  <= '0;
      inv_q   <= 1'b0;
      byp_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      data_q  <= data_d;
      inv_q   <= inv_d;
      byp_q   <= byp_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq: scoreboard queue fed at accept, drained at out_valid.
module tb_mix_columns_seq;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  logic [127:0] sb[$];

  mix_columns_seq_if bus ();

  mix_columns_seq #(.NCOL(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    logic [7:0] s;
    s = {b[6:0], 1'b0};
    return b[7] ? (s ^ 8'h1b) : s;
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction
  function automatic logic [7:0] mb(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction
  function automatic logic [7:0] md(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction
  function automatic logic [7:0] me(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  function automatic logic [31:0] ref_col(input logic [31:0] c, input logic inv);
    logic [7:0] a0, a1, a2, a3, r0, r1, r2, r3;
    {a0, a1, a2, a3} = c;
    if (!inv) begin
      r0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      r1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      r2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      r3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end else begin
      r0 = me(a0) ^ mb(a1) ^ md(a2) ^ m9(a3);
      r1 = m9(a0) ^ me(a1) ^ mb(a2) ^ md(a3);
      r2 = md(a0) ^ m9(a1) ^ me(a2) ^ mb(a3);
      r3 = mb(a0) ^ md(a1) ^ m9(a2) ^ me(a3);
    end
    return {r0, r1, r2, r3};
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] st, input logic inv, input logic byp);
    logic [127:0] r;
    r = st;
    if (!byp) begin
      for (int c = 0; c < 4; c++) r[127-32*c -: 32] = ref_col(st[127-32*c -: 32], inv);
    end
    return r;
  endfunction

  // ---------------- drivers (no checking) ----------------
  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [127:0] st, input logic inv, input logic byp,
                      output int acc_cyc, output bit ok);
    int n;
    bus.in_valid  = 1'b1;
    bus.in_state  = st;
    bus.in_inv    = inv;
    bus.in_bypass = byp;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = bus.in_ready;
    acc_cyc = cyc;
    if (!ok) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    bus.in_valid  = 1'b0;
    // Scramble the input bus: the block must work from its latched copy.
    bus.in_state  = {$urandom, $urandom, $urandom, $urandom};
    bus.in_inv    = 1'($urandom_range(0, 1));
    bus.in_bypass = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out(output int v_cyc, output bit ok);
    int n;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = bus.out_valid;
    v_cyc = cyc;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_state  = '0;
    bus.in_inv    = 1'b0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state: got %h expected 0", bus.out_state); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_hold: got in_ready=%b out_valid=%b expected 1/0", bus.in_ready, bus.out_valid); end
  endtask

  task automatic run_one(input string name, input logic [127:0] st, input logic inv,
                         input logic byp, input logic [127:0] expv);
    int acc, vc;
    bit ok;
    logic [127:0] e;
    send(st, inv, byp, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_accept: got timeout expected accept", name); return; end
    sb.push_back(expv);
    wait_out(vc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_valid: got timeout expected out_valid", name); void'(sb.pop_front()); return; end
    checks++; if (vc - acc !== 4) begin errors++; $display("FAIL %s_latency: got %0d expected 4", name, vc - acc); end
    e = sb.pop_front();
    checks++; if (bus.out_state !== e) begin errors++; $display("FAIL %s_data: got %h expected %h", name, bus.out_state, e); end
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL %s_release: got out_valid=%b in_ready=%b expected 0/1", name, bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_forward();
    run_one("fwd_fips", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
            128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
  endtask

  task automatic test_inverse();
    run_one("inv_fips", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0,
            128'hdb135345_f20a225c_01010101_c6c6c6c6);
    run_one("inv_d5", 128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 1'b1, 1'b0,
            128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5);
  endtask

  task automatic test_bypass();
    run_one("byp_fwd", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1,
            128'h00112233_44556677_8899aabb_ccddeeff);
    run_one("byp_inv", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1,
            128'h00112233_44556677_8899aabb_ccddeeff);
  endtask

  task automatic test_backpressure();
    int acc, vc;
    bit ok;
    logic [127:0] v1, v2, e;
    v1 = 128'h01234567_89abcdef_fedcba98_76543210;
    v2 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    bus.out_ready = 1'b0;
    send(v1, 1'b0, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_accept: got timeout expected accept"); bus.out_ready = 1'b1; return; end
    sb.push_back(ref_state(v1, 1'b0, 1'b0));
    wait_out(vc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_valid: got timeout expected out_valid"); end
    checks++; if (vc - acc !== 4) begin errors++; $display("FAIL bp_latency: got %0d expected 4", vc - acc); end
    // Queue the next state while the result is stalled.
    bus.in_valid  = 1'b1;
    bus.in_state  = v2;
    bus.in_inv    = 1'b0;
    bus.in_bypass = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b expected 1", i, bus.out_valid); end
      checks++; if (bus.out_state !== sb[0]) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h expected %h", i, bus.out_state, sb[0]); end
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    void'(sb.pop_front());
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
    sb.push_back(ref_state(v2, 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    bus.in_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_queued_accept: got in_ready=%b expected 0", bus.in_ready); end
    wait_out(vc, ok);
    checks++; if (!ok || vc - acc !== 4) begin errors++; $display("FAIL bp_queued_latency: got %0d (valid=%b) expected 4", vc - acc, ok); end
    e = sb.pop_front();
    checks++; if (bus.out_state !== e) begin errors++; $display("FAIL bp_queued_data: got %h expected %h", bus.out_state, e); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    fork
      begin : producer
        int acc;
        bit ok;
        logic [127:0] st;
        logic inv;
        for (int i = 0; i < 8; i++) begin
          st  = {$urandom, $urandom, $urandom, $urandom};
          inv = 1'($urandom_range(0, 1));
          send(st, inv, 1'b0, acc, ok);
          if (ok) sb.push_back(ref_state(st, inv, 1'b0));
        end
      end
      begin : consumer
        int vc, prev;
        bit ok;
        logic [127:0] e;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
          wait_out(vc, ok);
          checks++; if (!ok) begin errors++; $display("FAIL b2b_valid[%0d]: got timeout expected out_valid", i); end
          if (ok) begin
            if (i > 0) begin
              checks++; if (vc - prev !== 6) begin errors++; $display("FAIL b2b_interval[%0d]: got %0d expected 6", i, vc - prev); end
            end
            prev = vc;
            checks++;
            if (sb.size() == 0) begin
              errors++; $display("FAIL b2b_data[%0d]: got %h expected <empty scoreboard>", i, bus.out_state);
            end else begin
              e = sb.pop_front();
              if (bus.out_state !== e) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, bus.out_state, e); end
            end
          end
          @(negedge clk);
        end
      end
    join
  endtask

  task automatic test_reset_midop();
    int acc, vc;
    bit ok;
    logic [127:0] v, e;
    v = 128'hc0ffee00_12345678_9abcdef0_0badf00d;
    send(v, 1'b1, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_accept: got timeout expected accept"); end
    // Three more edges: columns 0, 1 and 2 have been written.
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_state !== 128'h0) begin errors++; $display("FAIL rst_mid_out_state: got %h expected 0", bus.out_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_partial: got out_valid=%b expected 0", bus.out_valid); end
    v = 128'h00112233_44556677_8899aabb_ccddeeff;
    send(v, 1'b0, 1'b0, acc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_mid_fresh_accept: got timeout expected accept"); return; end
    sb.push_back(ref_state(v, 1'b0, 1'b0));
    wait_out(vc, ok);
    checks++; if (!ok || vc - acc !== 4) begin errors++; $display("FAIL rst_mid_fresh_latency: got %0d (valid=%b) expected 4", vc - acc, ok); end
    e = sb.pop_front();
    checks++; if (bus.out_state !== e) begin errors++; $display("FAIL rst_mid_fresh_data: got %h expected %h", bus.out_state, e); end
    @(negedge clk);
  endtask

  initial begin
    cyc    = 0;
    checks = 0;
    errors = 0;
    test_reset();
    test_forward();
    test_inverse();
    test_bypass();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
